// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: serialises the core's ibus/dbus requests onto one single-beat memory channel.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed dbus priority.

typedef enum logic [2:0] {
   MSIZE1 = 3'd0,
   MSIZE2 = 3'd1,
   MSIZE4 = 3'd2,
   MSIZE8 = 3'd3
} msize_t;

typedef struct packed {
   logic        valid;
   logic [63:0] addr;
} ibus_req_t;

typedef struct packed {
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] data;
} ibus_resp_t;

typedef struct packed {
   logic        valid;
   logic [63:0] addr;
   msize_t      size;
   logic [7:0]  strobe;
   logic [63:0] data;
} dbus_req_t;

typedef struct packed {
   logic        addr_ok;
   logic        data_ok;
   logic [63:0] data;
} dbus_resp_t;

module core_bus_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  ibus_req_t         ireq,
   output ibus_resp_t        iresp,
   input  dbus_req_t         dreq,
   output dbus_resp_t        dresp,
   output logic              mreq_valid,
   output logic              mreq_write,
   output logic [ADDR_W-1:0] mreq_addr,
   output logic [2:0]        mreq_size,
   output logic [7:0]        mreq_strobe,
   output logic [DATA_W-1:0] mreq_data,
   input  logic              mreq_ready,
   input  logic              mresp_valid,
   input  logic [DATA_W-1:0] mresp_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam ibus_resp_t IRESP_IDLE = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'd0};
   localparam dbus_resp_t DRESP_IDLE = '{addr_ok: 1'b0, data_ok: 1'b0, data: 64'd0};

   state_t            state_r;
   state_t            state_s;
   logic              start_s;
   logic              pick_d_s;
   logic              grant_d_r;
   logic              mreq_valid_r;
   logic              mreq_write_r;
   logic [ADDR_W-1:0] mreq_addr_r;
   logic [2:0]        mreq_size_r;
   logic [7:0]        mreq_strobe_r;
   logic [DATA_W-1:0] mreq_data_r;
   ibus_resp_t        iresp_r;
   dbus_resp_t        dresp_r;
   logic [63:0]       beat_s;

   function automatic logic [31:0] iword_sel(input logic [63:0] beat, input logic hi);
      if (hi) begin
         return beat[63:32];
      end else begin
         return beat[31:0];
      end
   endfunction

   assign beat_s = 64'(mresp_data);

   // Next-state logic; start_s marks the IDLE edge that captures a new request.
   always_comb begin
      state_s = state_r;
      start_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ireq.valid || dreq.valid) begin
               state_s = ST_REQ;
               start_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mreq_ready) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mresp_valid) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_RESP: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_d_r;

   // Round-robin winner: on contention the client not granted last time wins.
   always_comb begin
      pick_d_s = 1'b0;
      if (ireq.valid && dreq.valid) begin
         pick_d_s = ~last_grant_d_r;
      end else begin
         pick_d_s = dreq.valid;
      end
   end

   // Last-grant history, reset to ibus so the first contended grant goes to dbus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_d_r <= 1'b0;
      end else if (start_s) begin
         last_grant_d_r <= pick_d_s;
      end else begin
         last_grant_d_r <= last_grant_d_r;
      end
   end
`else
   // Fixed priority: dbus wins whenever it requests.
   always_comb begin
      pick_d_s = dreq.valid;
   end
`endif

   // State, latched request and registered response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         grant_d_r     <= 1'b0;
         mreq_valid_r  <= 1'b0;
         mreq_write_r  <= 1'b0;
         mreq_addr_r   <= '0;
         mreq_size_r   <= 3'd0;
         mreq_strobe_r <= 8'd0;
         mreq_data_r   <= '0;
         iresp_r       <= IRESP_IDLE;
         dresp_r       <= DRESP_IDLE;
      end else begin
         state_r <= state_s;

         if (start_s) begin
            grant_d_r    <= pick_d_s;
            mreq_valid_r <= 1'b1;
            if (pick_d_s) begin
               mreq_write_r  <= |dreq.strobe;
               mreq_addr_r   <= ADDR_W'(dreq.addr);
               mreq_size_r   <= dreq.size;
               mreq_strobe_r <= dreq.strobe;
               mreq_data_r   <= DATA_W'(dreq.data);
            end else begin
               mreq_write_r  <= 1'b0;
               mreq_addr_r   <= ADDR_W'(ireq.addr);
               mreq_size_r   <= MSIZE4;
               mreq_strobe_r <= 8'd0;
               mreq_data_r   <= '0;
            end
         end else if ((state_r == ST_REQ) && mreq_ready) begin
            mreq_valid_r <= 1'b0;
         end else begin
            mreq_valid_r <= mreq_valid_r;
         end

         // Response is pulsed for the single RESP cycle; write data is not returned.
         if ((state_r == ST_WAIT) && mresp_valid) begin
            if (grant_d_r) begin
               dresp_r.addr_ok <= 1'b1;
               dresp_r.data_ok <= 1'b1;
               dresp_r.data    <= mreq_write_r ? 64'd0 : beat_s;
               iresp_r         <= IRESP_IDLE;
            end else begin
               iresp_r.addr_ok <= 1'b1;
               iresp_r.data_ok <= 1'b1;
               iresp_r.data    <= iword_sel(beat_s, mreq_addr_r[2]);
               dresp_r         <= DRESP_IDLE;
            end
         end else begin
            iresp_r <= IRESP_IDLE;
            dresp_r <= DRESP_IDLE;
         end
      end
   end

   assign mreq_valid  = mreq_valid_r;
   assign mreq_write  = mreq_write_r;
   assign mreq_addr   = mreq_addr_r;
   assign mreq_size   = mreq_size_r;
   assign mreq_strobe = mreq_strobe_r;
   assign mreq_data   = mreq_data_r;
   assign iresp       = iresp_r;
   assign dresp       = dresp_r;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed and randomized checks of core_bus_arbiter against a
// transaction-level model; honours ARB_ROUND_ROBIN_EN for the expected grant order.

module tb_core_bus_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [64:0]  ireq_v;
   logic [33:0]  iresp_v;
   logic [139:0] dreq_v;
   logic [65:0]  dresp_v;
   logic         mreq_valid, mreq_write, mreq_ready, mresp_valid;
   logic [63:0]  mreq_addr, mreq_data, mresp_data;
   logic [2:0]   mreq_size;
   logic [7:0]   mreq_strobe;

   always #5 clk = ~clk;

   core_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .reset(reset),
      .ireq(ireq_v), .iresp(iresp_v), .dreq(dreq_v), .dresp(dresp_v),
      .mreq_valid(mreq_valid), .mreq_write(mreq_write), .mreq_addr(mreq_addr),
      .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
      .mreq_ready(mreq_ready), .mresp_valid(mresp_valid), .mresp_data(mresp_data)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // client-side state: a request is held until its data_ok, unless deliberately dropped
   bit          i_pend, i_drop, d_pend, d_drop;
   logic [63:0] i_addr, d_addr, d_data;
   logic [2:0]  d_size;
   logic [7:0]  d_strobe;

   // knobs
   int          rdy_pct, rsp_pct, issue_pct, drop_pct;
   bit          auto_i, auto_d, fix_rd;
   logic [63:0] fix_val;

   // transaction-level reference: the one outstanding transaction and its progress
   bit          m_act, m_isd, m_acc, m_rsp, m_last_d;
   logic [63:0] m_addr, m_data, m_rdata;
   logic [2:0]  m_size;
   logic [7:0]  m_strobe;

   byte         obs_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      ireq_v = {i_pend & ~i_drop, i_addr};
      dreq_v = {d_pend & ~d_drop, d_addr, d_size, d_strobe, d_data};
   endtask

   task automatic new_i();
      i_pend = 1'b1;
      i_drop = 1'b0;
      i_addr = {$urandom, $urandom} & ~64'h3;
   endtask

   task automatic new_d();
      d_pend   = 1'b1;
      d_drop   = 1'b0;
      d_addr   = {$urandom, $urandom};
      d_size   = 3'($urandom_range(3));
      d_strobe = ($urandom_range(1) == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
      d_data   = {$urandom, $urandom};
   endtask

   task automatic check_outputs();
      bit          exp_req, exp_i, exp_d;
      logic [31:0] exp_word;
      exp_req = m_act && !m_acc;
      exp_i   = m_act && m_rsp && !m_isd;
      exp_d   = m_act && m_rsp && m_isd;
      check_eq("mreq_valid", mreq_valid, exp_req);
      if (exp_req) begin
         check_eq("mreq_addr", mreq_addr, m_addr);
         check_eq("mreq_write", mreq_write, m_isd && (m_strobe != 8'h00));
         check_eq("mreq_size", mreq_size, m_size);
         check_eq("mreq_strobe", mreq_strobe, m_strobe);
         if (m_isd && (m_strobe != 8'h00)) check_eq("mreq_data", mreq_data, m_data);
      end
      exp_word = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
      check_eq("iresp_ok", iresp_v[33:32], exp_i ? 2'b11 : 2'b00);
      check_eq("iresp_data", iresp_v[31:0], exp_i ? exp_word : 32'd0);
      check_eq("dresp_ok", dresp_v[65:64], exp_d ? 2'b11 : 2'b00);
      if (!exp_d) check_eq("dresp_data", dresp_v[63:0], 64'd0);
      else if (m_strobe == 8'h00) check_eq("dresp_data", dresp_v[63:0], m_rdata);
      if (iresp_v[32]) obs_q.push_back("I");
      if (dresp_v[64]) obs_q.push_back("D");
   endtask

   // One clock: choose inputs for the coming edge, advance the model, then check mid-cycle.
   task automatic step();
      bit iv, dv, win_d;
      if (m_act && m_rsp) begin
         if (m_isd) begin d_pend = 1'b0; d_drop = 1'b0; end
         else begin i_pend = 1'b0; i_drop = 1'b0; end
      end
      if (auto_i && !i_pend && ($urandom_range(99) < issue_pct)) new_i();
      if (auto_d && !d_pend && ($urandom_range(99) < issue_pct)) new_d();
      if (m_act && m_isd && d_pend && ($urandom_range(99) < drop_pct)) d_drop = 1'b1;
      if (m_act && !m_isd && i_pend && ($urandom_range(99) < drop_pct)) i_drop = 1'b1;
      drive();
      mreq_ready  = ($urandom_range(99) < rdy_pct);
      mresp_valid = m_act && m_acc && !m_rsp && ($urandom_range(99) < rsp_pct);
      mresp_data  = fix_rd ? fix_val : {$urandom, $urandom};
      if (mresp_valid) check_eq("mreq_valid_at_mresp", mreq_valid, 1'b0);

      iv = i_pend && !i_drop;
      dv = d_pend && !d_drop;
      if (!reset) begin
         m_act = 1'b0;
         m_last_d = 1'b0;
      end else if (!m_act) begin
         if (iv || dv) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (iv && dv) win_d = !m_last_d;
            else win_d = dv;
`else
            win_d = dv;
`endif
            m_act = 1'b1; m_acc = 1'b0; m_rsp = 1'b0;
            m_isd = win_d; m_last_d = win_d;
            if (win_d) begin
               m_addr = d_addr; m_size = d_size; m_strobe = d_strobe; m_data = d_data;
            end else begin
               m_addr = i_addr; m_size = 3'd2; m_strobe = 8'h00; m_data = 64'd0;
            end
         end
      end else if (!m_acc) begin
         if (mreq_ready) m_acc = 1'b1;
      end else if (!m_rsp) begin
         if (mresp_valid) begin m_rsp = 1'b1; m_rdata = mresp_data; end
      end else begin
         m_act = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic reset_mid(input string tag);
      reset = 1'b0;
      #1;
      check_eq({tag, "_mreq_valid"}, mreq_valid, 1'b0);
      check_eq({tag, "_iresp_ok"}, iresp_v[33:32], 2'b00);
      check_eq({tag, "_dresp_ok"}, dresp_v[65:64], 2'b00);
      i_pend = 1'b0; i_drop = 1'b0; d_pend = 1'b0; d_drop = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      byte exp_order[4];
      reset = 1'b0;
      {i_pend, i_drop, d_pend, d_drop, auto_i, auto_d, fix_rd} = 7'd0;
      {i_addr, d_addr, d_data, fix_val} = {4{64'd0}};
      d_size = 3'd0; d_strobe = 8'h00;
      {m_act, m_isd, m_acc, m_rsp, m_last_d} = 5'd0;
      {m_addr, m_data, m_rdata} = {3{64'd0}};
      m_size = 3'd0; m_strobe = 8'h00;
      rdy_pct = 100; rsp_pct = 100; issue_pct = 0; drop_pct = 0;
      mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_data = 64'd0;
      drive();
      @(negedge clk);
      step();
      step();
      reset = 1'b1;
      step();

      // ibus read with word selection from the upper half
      fix_rd = 1'b1; fix_val = 64'h1111_2222_3333_4444;
      i_pend = 1'b1; i_addr = 64'h8000_0004;
      step();
      check_eq("t1_size", mreq_size, 3'd2);
      check_eq("t1_strobe", mreq_strobe, 8'h00);
      step();
      step();
      check_eq("t1_data_ok", iresp_v[32], 1'b1);
      check_eq("t1_word", iresp_v[31:0], 32'h1111_2222);
      step();
      check_eq("t1_pulse_end", iresp_v[33:32], 2'b00);

      // dbus write stalled by mreq_ready
      d_pend = 1'b1; d_drop = 1'b0; d_addr = 64'h8000_1000; d_strobe = 8'hFF;
      d_size = 3'd3; d_data = 64'hDEAD_BEEF;
      rdy_pct = 0;
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("t2_stall_addr", mreq_addr, 64'h8000_1000);
         check_eq("t2_stall_write", mreq_write, 1'b1);
         check_eq("t2_stall_data", mreq_data, 64'hDEAD_BEEF);
      end
      rdy_pct = 100;
      step();
      step();
      check_eq("t2_dresp_ok", dresp_v[64], 1'b1);
      check_eq("t2_iresp_zero", iresp_v, 34'd0);
      step();

      // dbus read with valid dropped during WAIT
      reset = 1'b1;
      d_pend = 1'b1; d_drop = 1'b0; d_addr = 64'h8000_2008; d_strobe = 8'h00; d_size = 3'd3;
      step();
      step();
      d_drop = 1'b1;
      step();
      check_eq("t4_dresp_ok", dresp_v[64], 1'b1);
      check_eq("t4_dresp_data", dresp_v[63:0], 64'h1111_2222_3333_4444);
      step();
      step();
      fix_rd = 1'b0;

      // contention: fresh reset so last_grant starts at ibus
      reset_mid("t3_rst");
      obs_q.delete();
      auto_i = 1'b1; auto_d = 1'b1; issue_pct = 100;
      new_i(); new_d();
      for (int k = 0; k < 16; k++) step();
      auto_i = 1'b0; auto_d = 1'b0;
      for (int k = 0; k < 12; k++) step();
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = '{"D", "I", "D", "I"};
`else
      exp_order = '{"D", "D", "D", "D"};
`endif
      check_eq("t3_count", 64'(obs_q.size() >= 4), 64'd1);
      for (int k = 0; k < 4; k++) begin
         if (k < obs_q.size()) check_eq($sformatf("t3_grant%0d", k), obs_q[k], exp_order[k]);
      end

      // reset while waiting for the memory response, then a clean ibus read
      rsp_pct = 0;
      d_pend = 1'b1; d_drop = 1'b0; d_addr = 64'h8000_3000; d_strobe = 8'h00;
      step();
      step();
      step();
      reset_mid("t5_wait");
      rsp_pct = 100;
      i_pend = 1'b1; i_addr = 64'h8000_0100;
      step();
      step();
      step();
      check_eq("t5_after_ok", iresp_v[32], 1'b1);
      step();

      // reset during a REQ stall drops mreq_valid at once
      rdy_pct = 0;
      d_pend = 1'b1; d_drop = 1'b0; d_addr = 64'h8000_4000; d_strobe = 8'h0F;
      step();
      step();
      check_eq("t6_req_held", mreq_valid, 1'b1);
      reset_mid("t6_req");
      step();

      // randomized traffic
      rdy_pct = 60; rsp_pct = 50; issue_pct = 30; drop_pct = 10;
      auto_i = 1'b1; auto_d = 1'b1;
      for (int k = 0; k < 1500; k++) step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Two-client memory-bus arbiter sitting directly downstream of `core`. It consumes the core's instruction-bus (`ireq`/`iresp`) and data-bus (`dreq`/`dresp`) channels and serialises them onto one single-beat memory channel toward the memory system. At most one transaction is in flight at a time. The grant is latched from request acceptance through response delivery.

## Interface
Parameters:
- `ADDR_W`, 64: address width of both clients and the memory side.
- `DATA_W`, 64: data width of both clients and the memory side.

Ports:
- `clk` in 1: the only clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-low (0 = in reset). One clock; reset is asynchronous and active-low.
- `ireq` in `ibus_req_t`: instruction request; fields `valid`, `addr`.
- `iresp` out `ibus_resp_t`: fields `addr_ok`, `data_ok`, `data` (32-bit instruction).
- `dreq` in `dbus_req_t`: data request; fields `valid`, `addr`, `size`, `strobe`, `data`. A nonzero `strobe` means a write.
- `dresp` out `dbus_resp_t`: fields `addr_ok`, `data_ok`, `data`.
- `mreq_valid` out 1: memory request present.
- `mreq_write` out 1: 1 = write, 0 = read.
- `mreq_addr` out `ADDR_W`: request address.
- `mreq_size` out 3: access size (`msize_t` encoding). Instruction reads use MSIZE4.
- `mreq_strobe` out 8: byte enables. Reads drive 0.
- `mreq_data` out `DATA_W`: write data.
- `mreq_ready` in 1: memory accepts the request in this cycle.
- `mresp_valid` in 1: memory response beat in this cycle.
- `mresp_data` in `DATA_W`: read data. It is ignored for writes.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Samples `ireq.valid` and `dreq.valid`.
  - If any is set, it picks a winner (see Configuration), latches the winner's addr, size, strobe and data into internal registers, records the grant, and goes to REQ.
  - If neither is set, it stays in IDLE.
- REQ:
  - Drives `mreq_valid`=1 and all `mreq_*` fields from the latched registers. Outputs never depend combinationally on the client inputs.
  - On `mreq_ready`=1 it goes to WAIT.
- WAIT:
  - On `mresp_valid`=1 it latches `mresp_data` and goes to RESP.
  - `mresp_valid` seen in REQ or IDLE is a protocol error. It is ignored, and the verification bench asserts that it never happens.
- RESP:
  - Asserts `addr_ok`=1 and `data_ok`=1 to the granted client for exactly one cycle, with the latched data. The other client's ok signals stay 0.
  - Then goes to IDLE.
- Instruction data: `iresp.data` = `mresp_data[31:0]` when `addr[2]`=0, else `mresp_data[63:32]`. The selection uses the latched `addr[2]`.
- Dbus read data is returned unmodified; the core performs the sign extension.
- A client must hold `valid` and its fields stable until its `data_ok`.
- A client dropping `valid` mid-transaction does not abort the transaction. It completes and the `data_ok` pulse is still issued.
- The arbiter never reorders requests and never issues a second memory request before the first one's response.

## Timing
- Reset: state = IDLE and the grant register is cleared. All outputs are 0 while `reset`=0 and in the first cycle after release: `mreq_*`=0, `iresp`=0, `dresp`=0.
- Reset asserted mid-transaction returns immediately to IDLE and drops `mreq_valid` the same cycle. The memory side must be reset together with the arbiter.
- Minimum latency, with the request sampled at edge 0, memory ready immediately and the response one cycle after accept:
  - cycle 1: REQ, with `mreq_valid`=1 and `mreq_ready`=1;
  - cycle 2: WAIT, with `mresp_valid`=1;
  - cycle 3: RESP, `data_ok`=1.
- Back-to-back throughput is one transaction per 4 cycles.
- `mreq_ready` low stalls in REQ indefinitely with `mreq_*` held stable.
- `mresp_valid` low stalls in WAIT indefinitely.
- Requests are not sampled in RESP. The edge following RESP samples in IDLE, so a client that keeps `valid` high after `data_ok` issues a new transaction.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Undefined: fixed priority; dbus wins whenever both are valid in IDLE.
  - Defined: a 1-bit `last_grant` register is added (reset value = ibus). When both are valid, the client not granted last wins; a single requester always wins. `last_grant` updates on entry to REQ.

## Test plan
- Ibus read, `addr`=0x8000_0004, memory returns 0x1111_2222_3333_4444 immediately -> `iresp.data`=0x1111_2222 in cycle 3 with `addr_ok`=`data_ok`=1 for one cycle; `mreq_size`=MSIZE4, `mreq_strobe`=0.
- Dbus write, `addr`=0x8000_1000, `strobe`=0xFF, `data`=0xDEAD_BEEF, `mreq_ready` low for 5 cycles -> `mreq_*` stable for 5 cycles, `mreq_write`=1, `dresp.data_ok` pulse 2 cycles after accept, `iresp` stays 0.
- Both valid continuously for 4 transactions:
  - without the macro -> grant order D,D,D,D;
  - with `ARB_ROUND_ROBIN_EN` -> order D,I,D,I, with the first grant going to dbus because `last_grant` resets to ibus.
- `dreq.valid` dropped in WAIT -> `mresp_valid` still accepted, `dresp.data_ok` still pulses, then IDLE.
- `reset` driven low during WAIT -> `mreq_valid`=0 and all ok signals 0 immediately; after release, a new ibus request completes normally in 3 cycles.
